// File: rtl/mmss_timer.sv
// mmss_timer: minutes:seconds stopwatch/countdown core on clk_sys.
// A 1 Hz count prescaler and a free-running adjust-rate prescaler produce
// single-cycle enables. Per-cycle priority is rst > load > pause > adj >
// normal count. All outputs are registered.
module mmss_timer #(
    parameter int CLK_HZ  = 100000000,
    parameter int ADJ_HZ  = 2,
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60,
    parameter int W       = 7
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         pause,
    input  logic         adj,
    input  logic         sel,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_min,
    input  logic [W-1:0] load_sec,
    output logic [W-1:0] minutes,
    output logic [W-1:0] seconds,
    output logic         sec_tick,
    output logic         wrap,
    output logic         done
);

    localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam int P1W     = (CLK_HZ > 1)  ? $clog2(CLK_HZ)  : 1;
    localparam int PAW     = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

    localparam logic [P1W-1:0] P1_LAST  = P1W'(CLK_HZ - 1);
    localparam logic [PAW-1:0] PA_LAST  = PAW'(ADJ_DIV - 1);
    localparam logic [W-1:0]   SEC_LAST = W'(SEC_MOD - 1);
    localparam logic [W-1:0]   MIN_LAST = W'(MIN_MOD - 1);
    localparam logic [W-1:0]   ONE      = W'(1);

    logic [P1W-1:0] p1;
    logic [PAW-1:0] pa;
    logic           tick1;
    logic           tick_a;

    // Terminal-count enables; pause/adj gating of tick1 is handled by the
    // priority chain in the field register block.
    assign tick1  = (p1 == P1_LAST);
    assign tick_a = (pa == PA_LAST);

    // One-second prescaler: frozen by pause/adj so the partial second survives.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            p1 <= '0;
        end else if (load) begin
            p1 <= '0;
        end else if (!pause && !adj) begin
            if (tick1) p1 <= '0;
            else       p1 <= p1 + P1W'(1);
        end
    end

    // Adjust-rate prescaler: free running, only reset clears it.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pa <= '0;
        end else if (tick_a) begin
            pa <= '0;
        end else begin
            pa <= pa + PAW'(1);
        end
    end

    // Field registers, count pulses and the sticky countdown flag.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            minutes  <= '0;
            seconds  <= '0;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
            if (load) begin
                minutes <= (load_min > MIN_LAST) ? MIN_LAST : load_min;
                seconds <= (load_sec > SEC_LAST) ? SEC_LAST : load_sec;
                done    <= 1'b0;
            end else if (pause) begin
                // everything holds
            end else if (adj) begin
                if (tick_a) begin
                    if (sel) begin
                        seconds <= (seconds == SEC_LAST) ? '0 : seconds + ONE;
                    end else begin
                        minutes <= (minutes == MIN_LAST) ? '0 : minutes + ONE;
                    end
                end
            end else if (tick1) begin
                if (!dir) begin
                    sec_tick <= 1'b1;
                    if (seconds == SEC_LAST) begin
                        seconds <= '0;
                        if (minutes == MIN_LAST) begin
                            minutes <= '0;
                            wrap    <= 1'b1;
                        end else begin
                            minutes <= minutes + ONE;
                        end
                    end else begin
                        seconds <= seconds + ONE;
                    end
                end else if (minutes != '0 || seconds != '0) begin
                    sec_tick <= 1'b1;
                    if (seconds == '0) begin
                        seconds <= SEC_LAST;
                        minutes <= minutes - ONE;
                    end else begin
                        seconds <= seconds - ONE;
                    end
                    // about to reach 0:0 on this step
                    if (minutes == '0 && seconds == ONE) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// Scoreboard bench for mmss_timer (CLK_HZ=8, ADJ_HZ=2, 60/60, W=7).
// The stimulus process pushes a per-cycle expectation from a small
// total-seconds reference model, plus directed checkpoints with hand-computed
// values; a negedge monitor pops and compares against the DUT.
module tb_mmss_timer;

    localparam int W = 7;

    logic         clk_sys = 1'b0;
    logic         rst = 1'b1;
    logic         pause = 1'b0;
    logic         adj = 1'b0;
    logic         sel = 1'b0;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_min = '0;
    logic [W-1:0] load_sec = '0;
    logic [W-1:0] minutes;
    logic [W-1:0] seconds;
    logic         sec_tick;
    logic         wrap;
    logic         done;

    mmss_timer #(
        .CLK_HZ(8), .ADJ_HZ(2), .SEC_MOD(60), .MIN_MOD(60), .W(W)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .pause(pause), .adj(adj), .sel(sel),
        .dir(dir), .load(load), .load_min(load_min), .load_sec(load_sec),
        .minutes(minutes), .seconds(seconds), .sec_tick(sec_tick),
        .wrap(wrap), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    // kind 0: per-cycle expectation, 1: directed checkpoint, 2: phase mark
    typedef struct {
        int   kind;
        int   id;
        int   mn;
        int   sc;
        logic st;
        logic wr;
        logic dn;
        int   nt;
        int   nw;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ph_ticks = 0;
    int   ph_wraps = 0;
    int   cyc = 0;

    // reference model state
    int   m_p1 = 0, m_pa = 0, m_min = 0, m_sec = 0;
    logic m_done = 1'b0;

    // Monitor: drains everything pushed for the preceding rising edge.
    always @(negedge clk_sys) begin
        while (exp_q.size() > 0) begin
            ent_t e;
            e = exp_q.pop_front();
            if (e.kind == 0) begin
                cyc++;
                if (sec_tick === 1'b1) ph_ticks++;
                if (wrap === 1'b1) ph_wraps++;
                checks++;
                if (minutes !== W'(e.mn) || seconds !== W'(e.sc) || sec_tick !== e.st
                    || wrap !== e.wr || done !== e.dn) begin
                    failures++;
                    $display("FAIL cycle%0d got %0d:%0d tick=%b wrap=%b done=%b expected %0d:%0d tick=%b wrap=%b done=%b",
                             cyc, minutes, seconds, sec_tick, wrap, done,
                             e.mn, e.sc, e.st, e.wr, e.dn);
                end
            end else if (e.kind == 1) begin
                checks++;
                if (minutes !== W'(e.mn) || seconds !== W'(e.sc) || done !== e.dn) begin
                    failures++;
                    $display("FAIL point%0d got %0d:%0d done=%b expected %0d:%0d done=%b",
                             e.id, minutes, seconds, done, e.mn, e.sc, e.dn);
                end
                if (e.nt >= 0) begin
                    checks++;
                    if (ph_ticks != e.nt || ph_wraps != e.nw) begin
                        failures++;
                        $display("FAIL pulses%0d got sec_tick=%0d wrap=%0d expected sec_tick=%0d wrap=%0d",
                                 e.id, ph_ticks, ph_wraps, e.nt, e.nw);
                    end
                end
            end else begin
                ph_ticks = 0;
                ph_wraps = 0;
            end
        end
    end

    // One clock edge: model the spec using the inputs the DUT just sampled.
    task automatic step1();
        ent_t e;
        bit   t1, ta;
        int   tot;
        @(posedge clk_sys);
        e = '{kind: 0, id: 0, mn: 0, sc: 0, st: 1'b0, wr: 1'b0, dn: 1'b0, nt: -1, nw: 0};
        if (rst) begin
            m_p1 = 0; m_pa = 0; m_min = 0; m_sec = 0; m_done = 1'b0;
        end else begin
            t1 = (m_p1 == 7);
            ta = (m_pa == 3);
            m_pa = (m_pa + 1) % 4;
            if (load) m_p1 = 0;
            else if (!pause && !adj) m_p1 = (m_p1 + 1) % 8;
            if (load) begin
                m_min = (int'(load_min) > 59) ? 59 : int'(load_min);
                m_sec = (int'(load_sec) > 59) ? 59 : int'(load_sec);
                m_done = 1'b0;
            end else if (pause) begin
            end else if (adj) begin
                if (ta) begin
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min + 1) % 60;
                end
            end else if (t1) begin
                tot = m_min * 60 + m_sec;
                if (!dir) begin
                    e.wr = (tot == 3599);
                    e.st = 1'b1;
                    tot = (tot + 1) % 3600;
                end else if (tot != 0) begin
                    e.st = 1'b1;
                    tot = tot - 1;
                    if (tot == 0) m_done = 1'b1;
                end
                m_min = tot / 60;
                m_sec = tot % 60;
            end
        end
        e.mn = m_min;
        e.sc = m_sec;
        e.dn = m_done;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step1();
    endtask

    task automatic mark();
        exp_q.push_back('{kind: 2, id: 0, mn: 0, sc: 0, st: 1'b0, wr: 1'b0, dn: 1'b0, nt: -1, nw: 0});
    endtask

    task automatic point(input int id, input int mn, input int sc, input logic dn,
                         input int nt, input int nw);
        exp_q.push_back('{kind: 1, id: id, mn: mn, sc: sc, st: 1'b0, wr: 1'b0, dn: dn, nt: nt, nw: nw});
    endtask

    task automatic do_load(input int mn, input int sc);
        load = 1'b1;
        load_min = W'(mn);
        load_sec = W'(sc);
        step1();
        load = 1'b0;
    endtask

    initial begin
        // reset, then 61 seconds of up-count
        steps(2);
        point(1, 0, 0, 1'b0, -1, 0);
        rst = 1'b0;
        mark();
        steps(8 * 61);
        point(2, 1, 1, 1'b0, 61, 0);

        // rollover 59:59 -> 0:0
        do_load(59, 58);
        mark();
        steps(8);
        point(3, 59, 59, 1'b0, 1, 0);
        steps(8);
        point(4, 0, 0, 1'b0, 2, 1);

        // countdown to 0:0, sticky done
        dir = 1'b1;
        do_load(0, 2);
        mark();
        steps(8);
        point(5, 0, 1, 1'b0, 1, 0);
        steps(8);
        point(6, 0, 0, 1'b1, 2, 0);
        steps(16);
        point(7, 0, 0, 1'b1, 2, 0);
        dir = 1'b0;
        steps(2);
        dir = 1'b1;
        point(8, 0, 0, 1'b1, -1, 0);
        do_load(1, 0);
        point(9, 1, 0, 1'b0, -1, 0);
        dir = 1'b0;

        // adjust seconds and minutes, no carry and no wrap pulse
        do_load(0, 59);
        adj = 1'b1; sel = 1'b1;
        mark();
        steps(8);
        point(10, 0, 1, 1'b0, 0, 0);
        adj = 1'b0;
        do_load(59, 1);
        adj = 1'b1; sel = 1'b0;
        mark();
        steps(4);
        point(11, 0, 1, 1'b0, 0, 0);
        adj = 1'b0;

        // pause keeps the partial second
        do_load(3, 10);
        mark();
        steps(3);
        pause = 1'b1;
        steps(20);
        point(12, 3, 10, 1'b0, 0, 0);
        pause = 1'b0;
        steps(4);
        point(13, 3, 10, 1'b0, 0, 0);
        steps(1);
        point(14, 3, 11, 1'b0, 1, 0);
        pause = 1'b1; adj = 1'b1; sel = 1'b1;
        steps(8);
        sel = 1'b0;
        steps(8);
        point(15, 3, 11, 1'b0, 1, 0);
        pause = 1'b0; adj = 1'b0;

        // reset wins over load, reset clears done, clamping
        dir = 1'b1;
        do_load(0, 1);
        steps(8);
        point(16, 0, 0, 1'b1, -1, 0);
        dir = 1'b0;
        do_load(12, 33);
        steps(8);
        point(17, 12, 34, 1'b0, -1, 0);
        steps(3);
        rst = 1'b1; load = 1'b1; load_min = W'(5); load_sec = W'(5);
        step1();
        rst = 1'b0; load = 1'b0;
        point(18, 0, 0, 1'b0, -1, 0);
        dir = 1'b1;
        do_load(0, 1);
        steps(8);
        rst = 1'b1;
        step1();
        rst = 1'b0;
        point(19, 0, 0, 1'b0, -1, 0);
        dir = 1'b0;
        do_load(99, 75);
        point(20, 59, 59, 1'b0, -1, 0);
        mark();
        steps(8);
        point(21, 0, 0, 1'b0, 1, 1);

        @(negedge clk_sys);
        @(negedge clk_sys);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
